// File: rtl/fetch_line_seq.sv
// -----------------------------------------------------------------------------
// fetch_line_seq
//
// Fetch-side line sequencer. Issues 64-bit-aligned instruction SRAM reads,
// keeps returned lines in a 2-entry buffer and presents the current pc, the
// head line and the low halfword of the following line to the downstream
// aligner / RVC expander. pc walks by 2 (RVC) or 4 (RV32); a line is popped
// as soon as pc leaves it. A redirect flushes the buffer and restarts fetch.
//
// Handshakes:
//   SRAM request : a read is accepted in the cycle where sram_cs & sram_gnt;
//                  sram_addr is held stable while sram_cs is high and not
//                  granted. sram_rvalid comes exactly one cycle after accept.
//   Fetch output : the instruction at pc is consumed in a cycle where
//                  fetch_valid & !fet_stall & !redirect.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   redirect/redirect_pc jump/branch taken pulse and its target
//   fet_stall            decode stall, freezes pc and the buffer
//   sram_cs/sram_addr    read request and line address ([2:0] = 0)
//   sram_gnt             request accepted this cycle
//   sram_rvalid/rdata    read response
//   pc                   pc of the instruction presented
//   fetch_valid          instruction at pc fully available
//   fetch_line           head line (line containing pc), 0 when empty
//   fetch_line_nxt_lo    entry1[15:0], 0 when entry1 absent
//   o_dbg_state          request FSM state (0 IDLE, 1 REQ, 2 WAIT)
// -----------------------------------------------------------------------------
module fetch_line_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fet_stall,
    output logic        sram_cs,
    output logic [31:0] sram_addr,
    input  logic        sram_gnt,
    input  logic        sram_rvalid,
    input  logic [63:0] sram_rdata,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic [63:0] fetch_line,
    output logic [15:0] fetch_line_nxt_lo,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [63:0] r_line0;       // buffer head
    logic [63:0] r_line1;       // buffer entry1
    logic [1:0]  r_cnt;         // lines held, 0..2
    logic        r_drop;        // discard the response of the request in flight

    logic        w_accept;
    logic        w_rsp;
    logic        w_push;
    logic        w_pop;
    logic        w_advance;
    logic        w_fetch_valid;
    logic        w_rv16;
    logic        w_space;
    logic [15:0] w_half;
    logic [31:0] w_pc_inc;
    logic [1:0]  w_cnt_nxt;

    assign w_accept = (r_state == ST_REQ) && sram_gnt;
    // Only a WAIT state owns a response; anything arriving otherwise (e.g. a
    // late beat after reset) has no outstanding request and is ignored.
    assign w_rsp    = (r_state == ST_WAIT) && sram_rvalid;
    assign w_push   = w_rsp && !r_drop && !redirect;

    assign w_half   = r_line0[{r_pc[2:1], 4'b0000} +: 16];
    assign w_rv16   = (w_half[1:0] != 2'b11);

    // A 32-bit instruction starting in the last halfword needs entry1 too.
    assign w_fetch_valid = (r_cnt != 2'd0) &&
                           ((r_pc[2:1] != 2'b11) || w_rv16 || (r_cnt == 2'd2));

    assign w_advance = w_fetch_valid && !fet_stall && !redirect;
    assign w_pc_inc  = r_pc + (w_rv16 ? 32'd2 : 32'd4);
    assign w_pop     = w_advance && (w_pc_inc[31:3] != r_pc[31:3]);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (redirect) begin
            w_cnt_nxt = 2'd0;
        end else begin
            w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Credit: with no request outstanding, room exists if fewer than 2 lines
    // will be held after this cycle's push/pop.
    assign w_space = (w_cnt_nxt != 2'd2);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_space) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_accept) begin
                    w_state_nxt = ST_WAIT;
                end else if (redirect) begin
                    // Un-granted request to the old stream is withdrawn.
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sram_rvalid) begin
                    w_state_nxt = w_space ? ST_REQ : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        sram_cs           = (r_state == ST_REQ);
        sram_addr         = r_req_addr;
        o_dbg_state       = r_state;
        pc                = r_pc;
        fetch_valid       = w_fetch_valid;
        fetch_line        = (r_cnt != 2'd0) ? r_line0 : 64'd0;
        fetch_line_nxt_lo = (r_cnt == 2'd2) ? r_line1[15:0] : 16'd0;
    end

    // ---------------- pc, request address, line buffer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC & ~32'd1;
            r_req_addr <= RESET_PC & ~32'd7;
            r_line0    <= 64'd0;
            r_line1    <= 64'd0;
            r_cnt      <= 2'd0;
            r_drop     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (redirect) begin
                r_pc       <= redirect_pc & ~32'd1;
                r_req_addr <= redirect_pc & ~32'd7;
                // A request granted now, or one whose response has not yet
                // returned, belongs to the old stream.
                r_drop     <= w_accept || ((r_state == ST_WAIT) && !sram_rvalid);
            end else begin
                if (w_advance) begin
                    r_pc <= w_pc_inc;
                end
                if (w_accept) begin
                    r_req_addr <= r_req_addr + 32'd8;
                end
                if (w_rsp) begin
                    r_drop <= 1'b0;
                end
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_cnt == 2'd0) begin
                            r_line0 <= sram_rdata;
                        end else begin
                            r_line1 <= sram_rdata;
                        end
                    end
                    2'b01: begin
                        r_line0 <= r_line1;
                    end
                    2'b11: begin
                        // Shift and load in the same cycle.
                        if (r_cnt == 2'd2) begin
                            r_line0 <= r_line1;
                            r_line1 <= sram_rdata;
                        end else begin
                            r_line0 <= sram_rdata;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_line_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_line_seq
//
// Memory content is a pure function of address, so the instruction stream
// from any start pc is known: each instruction's length comes from its low
// halfword. On reset/redirect the expected (pc, instruction) stream is pushed
// into exp_q; a negedge monitor pops one entry per consumed instruction and
// compares it with what the DUT presents. Request addresses are tracked the
// same way (start line, +8 per accept).
// -----------------------------------------------------------------------------
module tb_fetch_line_seq;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fet_stall = 1'b0;
    logic        sram_cs;
    logic [31:0] sram_addr;
    logic        sram_gnt = 1'b0;
    logic        sram_rvalid;
    logic [63:0] sram_rdata;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [63:0] fetch_line;
    logic [15:0] fetch_line_nxt_lo;
    logic [1:0]  dbg_state;

    fetch_line_seq #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .fet_stall         (fet_stall),
        .sram_cs           (sram_cs),
        .sram_addr         (sram_addr),
        .sram_gnt          (sram_gnt),
        .sram_rvalid       (sram_rvalid),
        .sram_rdata        (sram_rdata),
        .pc                (pc),
        .fetch_valid       (fetch_valid),
        .fetch_line        (fetch_line),
        .fetch_line_nxt_lo (fetch_line_nxt_lo),
        .o_dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    int          mem_mode  = 0;   // 0: every halfword looks 32-bit, 1: mixed RVC
    int          stall_ctl = 0;   // 0 off, 1 on, 2 random
    int          gnt_ctl   = 1;   // 0 never, 1 always, 2 random
    logic        acc_flag  = 1'b0;
    logic [31:0] acc_addr  = 32'd0;

    logic [63:0] exp_q[$];        // {pc, instruction}
    logic [31:0] model_pc;
    logic [31:0] exp_req;
    logic        prev_rst   = 1'b0;
    logic        prev_redir = 1'b0;
    int          idle_run   = 0;

    // ---------------- memory and reference model ----------------
    function automatic logic [15:0] mem_hw(input logic [31:0] a, input int mode);
        logic [31:0] x;
        x = a * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 13);
        if (mode == 0) return {x[15:2], 2'b11};
        return {x[15:2], (x[16] ? 2'b11 : x[1:0])};
    endfunction

    function automatic logic [63:0] mem_line(input logic [31:0] a, input int mode);
        logic [31:0] la;
        la = a & ~32'd7;
        return {mem_hw(la + 32'd6, mode), mem_hw(la + 32'd4, mode),
                mem_hw(la + 32'd2, mode), mem_hw(la, mode)};
    endfunction

    task automatic refill();
        logic [15:0] lo;
        logic [15:0] hi;
        repeat (16) begin
            lo = mem_hw(model_pc, mem_mode);
            if (lo[1:0] != 2'b11) begin
                exp_q.push_back({model_pc, 16'h0000, lo});
                model_pc = model_pc + 32'd2;
            end else begin
                hi = mem_hw(model_pc + 32'd2, mem_mode);
                exp_q.push_back({model_pc, hi, lo});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        model_pc = start & ~32'd1;
        exp_req  = start & ~32'd7;
        refill();
    endtask

    function automatic logic [31:0] dut_instr();
        logic [79:0] win;
        logic [15:0] lo;
        logic [15:0] hi;
        int k;
        win = {fetch_line_nxt_lo, fetch_line};
        k   = int'(pc[2:1]);
        lo  = win[16*k +: 16];
        hi  = win[16*k + 16 +: 16];
        if (lo[1:0] != 2'b11) return {16'h0000, lo};
        return {hi, lo};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- SRAM responder ----------------
    initial begin
        sram_rvalid = 1'b0;
        sram_rdata  = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            sram_rvalid = acc_flag;
            sram_rdata  = acc_flag ? mem_line(acc_addr, mem_mode) : {$urandom, $urandom};
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [63:0] cur;
        forever begin
            @(negedge clk);
            acc_flag = sram_cs & sram_gnt;
            acc_addr = sram_addr;
            if (rst) begin
                restart(RESET_PC);
                prev_rst   = 1'b1;
                prev_redir = 1'b0;
                idle_run   = 0;
            end else begin
                if (prev_rst) begin
                    chk("rst_cs", sram_cs, 0);
                    chk("rst_valid", fetch_valid, 0);
                    chk("rst_pc", pc, RESET_PC & ~32'd1);
                    chk("rst_line", fetch_line, 0);
                    chk("rst_nxt_lo", fetch_line_nxt_lo, 0);
                end
                if (prev_redir) chk("redir_valid", fetch_valid, 0);
                if (sram_cs) begin
                    chk("req_addr", sram_addr, exp_req);
                    if (sram_gnt) exp_req = exp_req + 32'd8;
                end
                if (fetch_valid) begin
                    idle_run = 0;
                    cur = exp_q[0];
                    chk("fetch_pc", pc, cur[63:32]);
                    chk("fetch_instr", dut_instr(), cur[31:0]);
                    if (!fet_stall && !redirect) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() < 8) refill();
                    end
                end else begin
                    idle_run++;
                    if (idle_run >= 80) begin
                        chk("liveness", idle_run, 0);
                        idle_run = 0;
                    end
                end
                if (redirect) restart(redirect_pc);
                prev_rst   = 1'b0;
                prev_redir = redirect;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input logic t_rst, input logic t_redir,
                        input logic [31:0] t_pc, input int t_mode);
        @(posedge clk);
        #1;
        rst         = t_rst;
        redirect    = t_redir;
        redirect_pc = t_redir ? t_pc : $urandom;
        mem_mode    = t_mode;
        fet_stall   = (stall_ctl == 2) ? ($urandom_range(0, 6) == 0) : (stall_ctl == 1);
        sram_gnt    = (gnt_ctl == 2) ? ($urandom_range(0, 3) != 0) : (gnt_ctl == 1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [31:0] tgt;

        // Reset, all-RV32 lines, grant always: valid at cycle 3, no bubbles.
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int c = 0; c < 25; c++) begin
            tick(0, 0, 0, 0);
            @(negedge clk);
            if (c == 1) chk("t1_req_cs", sram_cs, 1);
            chk("t1_valid_cycle", fetch_valid, (c >= 3));
        end

        // Redirect to a line-crossing 32-bit instruction: needs both lines.
        tick(0, 1, 32'h0000_1006, 0);
        for (int c = 1; c <= 4; c++) begin
            tick(0, 0, 0, 0);
            @(negedge clk);
            chk("t2_wait_two_lines", fetch_valid, 0);
        end
        repeat (20) tick(0, 0, 0, 0);

        // Stall: buffer fills, requests stop, consumption resumes at release.
        stall_ctl = 1;
        for (int c = 0; c < 10; c++) begin
            tick(0, 0, 0, 0);
            @(negedge clk);
            if (c == 9) begin
                chk("t4_cs_idle", sram_cs, 0);
                chk("t4_valid_held", fetch_valid, 1);
            end
        end
        stall_ctl = 0;
        tick(0, 0, 0, 0);
        @(negedge clk);
        chk("t4_resume", fetch_valid, 1);
        repeat (6) tick(0, 0, 0, 0);

        // No grant: request held stable; redirect during REQ withdraws it.
        gnt_ctl = 0;
        tick(0, 1, 32'h0000_2000, 0);
        for (int c = 1; c <= 6; c++) begin
            tick(0, 0, 0, 0);
            @(negedge clk);
            if (c >= 2) chk("t5_cs_hold", sram_cs, 1);
            chk("t5_no_valid", fetch_valid, 0);
        end
        tick(0, 1, 32'h0000_3000, 0);
        tick(0, 0, 0, 0);
        @(negedge clk);
        chk("t5_cs_drop", sram_cs, 0);
        gnt_ctl = 1;
        repeat (10) tick(0, 0, 0, 0);

        // Address wrap with a mixed RVC stream.
        tick(0, 1, 32'hFFFF_FFE8, 1);
        repeat (30) tick(0, 0, 0, 1);

        // Reset in the accept cycle: the response arrives after reset.
        tick(0, 1, 32'h0000_5000, 1);
        repeat (8) tick(0, 0, 0, 1);
        for (int c = 0; c < 10; c++) begin
            tick(0, 0, 0, 1);
            #1;
            if (sram_cs) begin
                rst = 1'b1;
                break;
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick(0, 0, 0, 1);
            @(negedge clk);
            chk("t6_late_rvalid", fetch_valid, (c >= 3));
        end
        repeat (10) tick(0, 0, 0, 1);

        // Randomized traffic.
        stall_ctl = 2;
        gnt_ctl   = 2;
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                tick(1, 0, 0, 1);
            end else if (r < 33) begin
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFC0 | ($urandom & 32'h3E);
                else tgt = $urandom;
                tick(0, 1, tgt, 1);
            end else begin
                tick(0, 0, 0, 1);
            end
        end
        stall_ctl = 0;
        repeat (4) tick(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
